idli_urx_arb_m: RTL and testbench

IDLI_URX_ARB_M -- requirements
Module: idli_urx_arb_m

---
 rtl/idli_pkg.sv | 7 +
 rtl/idli_urx_arb_pick_m.sv | 14 +
 rtl/idli_urx_arb_m.sv | 72 +++++++
 tb/tb_idli_urx_arb_m.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types for the UART receive arbiter (core counter, data slice, FSM state, source index)
package idli_pkg;
  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;
  typedef enum logic {IDLE, LOCK} urx_arb_state_t;
  typedef logic urx_src_t;
endpackage

// File: rtl/idli_urx_arb_pick_m.sv
// idli_urx_arb_pick_m: combinational winner pick between two sources
// Ports:
//   vld    - per-source valid flags
//   prio   - source that wins when both are valid
//   winner - chosen source index (0 when neither is valid)
module idli_urx_arb_pick_m
  import idli_pkg::*;
(
  input  logic [1:0] vld,
  input  urx_src_t   prio,
  output urx_src_t   winner
);
  assign winner = (&vld) ? prio : vld[1];
endmodule

// File: rtl/idli_urx_arb_m.sv
// idli_urx_arb_m: arbitrates two UART receivers onto the EX slice stream, locking a source for a whole 4-slice word
// Ports:
//   i_uarb_gck / i_uarb_rst_n     - clock, async active-low reset
//   i_uarb_ctr                    - core slice counter (0..3)
//   i_uarb_src_data/_vld          - per-source slice and word-ready flag
//   o_uarb_src_acp                - per-source accept (one-hot or zero)
//   o_uarb_data/_vld/_sel         - slice, valid and source index presented to EX
//   i_uarb_acp                    - EX accept
//   o_uarb_busy                   - a word transfer is locked
// Build option: IDLI_URX_ARB_RR_EN enables round-robin tie-break; otherwise source 0 always wins ties.
module idli_urx_arb_m
  import idli_pkg::*;
(
  input  logic           i_uarb_gck,
  input  logic           i_uarb_rst_n,
  input  ctr_t           i_uarb_ctr,
  input  slice_t [1:0]   i_uarb_src_data,
  input  logic   [1:0]   i_uarb_src_vld,
  output logic   [1:0]   o_uarb_src_acp,
  output slice_t         o_uarb_data,
  output logic           o_uarb_vld,
  output logic           o_uarb_sel,
  input  logic           i_uarb_acp,
  output logic           o_uarb_busy
);
  urx_arb_state_t state_q, state_d;
  urx_src_t sel_q, sel_d, winner, cur, prio;
  logic grant, done, act;
`ifdef IDLI_URX_ARB_RR_EN
  urx_src_t prio_q, prio_d;
  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif
  idli_urx_arb_pick_m u_pick (
    .vld    (i_uarb_src_vld),
    .prio   (prio),
    .winner (winner)
  );
  assign grant = state_q == IDLE && i_uarb_ctr == 2'd0 && |i_uarb_src_vld;
  assign done  = state_q == LOCK && i_uarb_ctr == 2'd3 && i_uarb_acp && i_uarb_src_vld[sel_q];
  // outputs are forced low combinationally while reset is held
  assign act   = i_uarb_rst_n && (state_q == LOCK || grant);
  assign cur   = state_q == LOCK ? sel_q : winner;
  always_comb begin
    state_d = grant ? LOCK : done ? IDLE : state_q;
    sel_d   = grant ? winner : sel_q;
`ifdef IDLI_URX_ARB_RR_EN
    prio_d  = done ? ~sel_q : prio_q;
`endif
  end
  always_ff @(posedge i_uarb_gck or negedge i_uarb_rst_n) begin
    if (!i_uarb_rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
`ifdef IDLI_URX_ARB_RR_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef IDLI_URX_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end
  assign o_uarb_data    = act ? i_uarb_src_data[cur] : '0;
  assign o_uarb_vld     = act && i_uarb_src_vld[cur];
  assign o_uarb_src_acp = !act ? 2'b00 : cur ? {i_uarb_acp, 1'b0} : {1'b0, i_uarb_acp};
  assign o_uarb_sel     = act && cur;
  assign o_uarb_busy    = act;
endmodule

// File: tb/tb_idli_urx_arb_m.sv
// tb_idli_urx_arb_m: directed and random checks of the UART receive arbiter against a word-level reference model
module tb_idli_urx_arb_m;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ctr = '0;
  logic [1:0] vld = '0;
  logic [1:0][3:0] data = '0;
  logic acp = 1'b0;
  logic [1:0] src_acp;
  logic [3:0] dout;
  logic vout, sel, busy;
  logic [15:0] w0 = '0, w1 = '0;
  logic [1:0] cnt = '0;
  int vec = 0, bad = 0;
  int owner = -1;
  int prio = 0;
  int gq[$];
`ifdef IDLI_URX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  always #5 clk = ~clk;
  idli_urx_arb_m dut (
    .i_uarb_gck      (clk),
    .i_uarb_rst_n    (rst_n),
    .i_uarb_ctr      (ctr),
    .i_uarb_src_data (data),
    .i_uarb_src_vld  (vld),
    .o_uarb_src_acp  (src_acp),
    .o_uarb_data     (dout),
    .o_uarb_vld      (vout),
    .o_uarb_sel      (sel),
    .i_uarb_acp      (acp),
    .o_uarb_busy     (busy)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t ctr=%0d)", tag, got, exp, $time, cnt);
    end
  endtask
  // one core cycle: drive at negedge, check shortly after, advance model at posedge
  task automatic cyc(input logic r, input logic [1:0] v, input logic a);
    int cur;
    bit act;
    logic [3:0] s0, s1;
    @(negedge clk);
    s0 = w0[4*cnt +: 4];
    s1 = w1[4*cnt +: 4];
    rst_n = r; ctr = cnt; vld = v; acp = a;
    data[0] = s0; data[1] = s1;
    if (!r) begin
      owner = -1;
      prio = 0;
    end
    act = 1'b0;
    cur = 0;
    if (r && owner >= 0) begin
      act = 1'b1;
      cur = owner;
    end else if (r && cnt == 2'd0 && v != 2'b00) begin
      act = 1'b1;
      cur = (v == 2'b11) ? (RR ? prio : 0) : (v == 2'b10 ? 1 : 0);
    end
    #1;
    check("busy", 16'(busy), 16'(act));
    check("sel", 16'(sel), act ? 16'(cur) : 16'd0);
    check("vld", 16'(vout), 16'(act && v[cur]));
    check("src_acp", 16'(src_acp), (act && a) ? (cur == 1 ? 16'd2 : 16'd1) : 16'd0);
    if (!r) check("rst_data", 16'(dout), 16'd0);
    else if (act && v[cur]) check("data", 16'(dout), 16'(cur == 1 ? s1 : s0));
    @(posedge clk);
    if (r) begin
      if (owner < 0 && act) begin
        owner = cur;
        gq.push_back(cur);
      end else if (owner >= 0 && cnt == 2'd3 && a && v[owner]) begin
        prio = 1 - owner;
        owner = -1;
      end
    end
    cnt++;
  endtask
  task automatic do_reset();
    repeat (2) cyc(1'b0, 2'b00, 1'b0);
  endtask
  task automatic align();
    while (cnt != 2'd0) cyc(1'b1, 2'b00, 1'b1);
  endtask
  function automatic logic [15:0] gat(input int i);
    return (gq.size() > i) ? 16'(gq[i]) : 16'hFFFF;
  endfunction
  initial begin
    do_reset();
    align();
    gq.delete();
    w0 = 16'hA5C3;
    w1 = 16'h0F0F;
    repeat (4) cyc(1'b1, 2'b01, 1'b1);
    repeat (4) cyc(1'b1, 2'b00, 1'b1);
    check("s1_grants", 16'(gq.size()), 16'd1);
    check("s1_src", gat(0), 16'd0);
    do_reset();
    align();
    gq.delete();
    w0 = 16'h1234;
    w1 = 16'h5678;
    repeat (12) cyc(1'b1, 2'b11, 1'b1);
    check("s2_grants", 16'(gq.size()), 16'd3);
    check("s2_g0", gat(0), 16'd0);
    check("s2_g1", gat(1), RR ? 16'd1 : 16'd0);
    check("s2_g2", gat(2), 16'd0);
    do_reset();
    align();
    gq.delete();
    repeat (3) cyc(1'b1, 2'b01, 1'b1);
    cyc(1'b1, 2'b01, 1'b0);
    repeat (4) cyc(1'b1, 2'b11, 1'b1);
    repeat (4) cyc(1'b1, 2'b00, 1'b1);
    check("s3_grants", 16'(gq.size()), 16'd1);
    check("s3_src", gat(0), 16'd0);
    do_reset();
    align();
    gq.delete();
    cyc(1'b1, 2'b00, 1'b1);
    repeat (3) cyc(1'b1, 2'b10, 1'b1);
    check("s4_early", 16'(gq.size()), 16'd0);
    repeat (4) cyc(1'b1, 2'b10, 1'b1);
    check("s4_grants", 16'(gq.size()), 16'd1);
    check("s4_src", gat(0), 16'd1);
    do_reset();
    align();
    gq.delete();
    repeat (2) cyc(1'b1, 2'b01, 1'b1);
    repeat (2) cyc(1'b0, 2'b01, 1'b1);
    repeat (4) cyc(1'b1, 2'b10, 1'b1);
    check("s5_grants", 16'(gq.size()), 16'd2);
    check("s5_src", gat(1), 16'd1);
    repeat (600) begin
      if (cnt == 2'd0) begin
        w0 = 16'($urandom);
        w1 = 16'($urandom);
      end
      cyc($urandom_range(0, 49) != 0, 2'($urandom), $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
